// File: rtl/sec_habilita_contadores.sv
// Counter-enable sequencer: one-hot enables to N_CH counter blocks.
// Single-request or round-robin auto mode; done/timeout exit with a dead cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   sel, sel_valid      : single-request channel and strobe (IDLE only)
//   modo_auto           : 0 single request, 1 round-robin over canal_mask
//   canal_mask, done    : auto-mode eligibility, per-counter completion
//   enable_cont         : one-hot counter enable (zero outside ACTIVO)
//   ch_activo, busy     : current channel index, high in ACTIVO/PAUSA
//   timeout_err         : 1-cycle pulse on timeout exit
//   sel_invalido        : 1-cycle pulse on out-of-range request
module sec_habilita_contadores #(
  parameter int N_CH    = 4,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  input  logic             modo_auto,
  input  logic [N_CH-1:0]  canal_mask,
  input  logic [N_CH-1:0]  done,
  output logic [N_CH-1:0]  enable_cont,
  output logic [SEL_W-1:0] ch_activo,
  output logic             busy,
  output logic             timeout_err,
  output logic             sel_invalido
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVO = 2'd1,
    PAUSA  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_CH-1:0]  en_d;
  logic [SEL_W-1:0] ch_d;
  logic             busy_d;
  logic             tmo_d;
  logic             inv_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [SEL_W-1:0] pick;
  logic             found;
  logic             hit;
  logic             tmo_hit;
  logic             sel_ok;
  logic [SEL_W-1:0] ch_next;

  // Round-robin: first set bit at or above rr, else first set bit overall.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (!found && canal_mask[j] && j >= int'(rr_q)) begin
        found = 1'b1;
        pick  = SEL_W'(j);
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (!found && canal_mask[j]) begin
        found = 1'b1;
        pick  = SEL_W'(j);
      end
    end
  end

  // The registered one-hot enable selects the active channel's done bit.
  assign hit     = |(done & enable_cont);
  assign tmo_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));
  assign sel_ok  = int'(sel) < N_CH;
  assign ch_next = (int'(ch_activo) >= N_CH - 1) ? '0
                                                  : ch_activo + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    en_d    = enable_cont;
    ch_d    = ch_activo;
    busy_d  = busy;
    tmo_d   = 1'b0;
    inv_d   = 1'b0;
    rr_d    = rr_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        en_d   = '0;
        busy_d = 1'b0;
        if (modo_auto) begin
          if (found) begin
            state_d = ACTIVO;
            en_d    = ONE << pick;
            ch_d    = pick;
            busy_d  = 1'b1;
            timer_d = TW'(1);
          end
        end else if (sel_valid) begin
          if (sel_ok) begin
            state_d = ACTIVO;
            en_d    = ONE << sel;
            ch_d    = sel;
            busy_d  = 1'b1;
            timer_d = TW'(1);
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      ACTIVO: begin
        if (hit || tmo_hit) begin
          state_d = PAUSA;
          en_d    = '0;
          rr_d    = ch_next;
          timer_d = '0;
          // done wins over a simultaneous timeout
          tmo_d   = !hit;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      PAUSA: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      enable_cont  <= '0;
      ch_activo    <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      sel_invalido <= 1'b0;
      rr_q         <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      enable_cont  <= en_d;
      ch_activo    <= ch_d;
      busy         <= busy_d;
      timeout_err  <= tmo_d;
      sel_invalido <= inv_d;
      rr_q         <= rr_d;
      timer_q      <= timer_d;
    end
  end

endmodule

// File: tb/tb_sec_habilita_contadores.sv
// Testbench for sec_habilita_contadores (TIMEOUT=8).
// Vector table for single-request flow plus directed multi-cycle sequences.
module tb_sec_habilita_contadores;

  logic       clk;
  logic       reset;
  logic [3:0] sel;
  logic       sel_valid;
  logic       modo_auto;
  logic [3:0] canal_mask;
  logic [3:0] done;
  logic [3:0] enable_cont;
  logic [3:0] ch_activo;
  logic       busy;
  logic       timeout_err;
  logic       sel_invalido;

  int total = 0;
  int bad   = 0;

  sec_habilita_contadores #(
    .N_CH   (4),
    .SEL_W  (4),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .modo_auto   (modo_auto),
    .canal_mask  (canal_mask),
    .done        (done),
    .enable_cont (enable_cont),
    .ch_activo   (ch_activo),
    .busy        (busy),
    .timeout_err (timeout_err),
    .sel_invalido(sel_invalido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic       sv;
    logic [3:0] dn;
    logic [3:0] en;
    logic [3:0] ch;
    logic       busy;
    logic       inv;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_en(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (enable_cont != 4'h0) ok = 1'b1;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Invariant: at most one enable, and it matches ch_activo.
  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (!$onehot0(enable_cont) ||
          (enable_cont != 4'h0 && enable_cont != (4'h1 << ch_activo))) begin
        bad++;
        $display("FAIL onehot: en=%b ch=%0d", enable_cont, ch_activo);
      end
    end
  end

  logic [3:0] exp_ord[4];
  logic       ok;
  int         ne;
  int         nt;

  initial begin
    tbl[0]  = '{4'd2, 1'b1, 4'h0, 4'h4, 4'd2, 1'b1, 1'b0};
    tbl[1]  = '{4'd2, 1'b0, 4'h0, 4'h4, 4'd2, 1'b1, 1'b0};
    tbl[2]  = '{4'd2, 1'b0, 4'h0, 4'h4, 4'd2, 1'b1, 1'b0};
    tbl[3]  = '{4'd2, 1'b0, 4'h0, 4'h4, 4'd2, 1'b1, 1'b0};
    tbl[4]  = '{4'd2, 1'b0, 4'h0, 4'h4, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{4'd2, 1'b0, 4'h4, 4'h0, 4'd2, 1'b1, 1'b0};
    tbl[6]  = '{4'd2, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 1'b0};
    tbl[7]  = '{4'd9, 1'b1, 4'h0, 4'h0, 4'd2, 1'b0, 1'b1};
    tbl[8]  = '{4'd9, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 1'b0};
    tbl[9]  = '{4'd3, 1'b1, 4'h0, 4'h8, 4'd3, 1'b1, 1'b0};
    tbl[10] = '{4'd3, 1'b0, 4'h1, 4'h8, 4'd3, 1'b1, 1'b0};
    tbl[11] = '{4'd3, 1'b0, 4'h8, 4'h0, 4'd3, 1'b1, 1'b0};
    tbl[12] = '{4'd1, 1'b1, 4'h0, 4'h0, 4'd3, 1'b0, 1'b0};
    tbl[13] = '{4'd1, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0, 1'b0};
    exp_ord[0] = 4'h1;
    exp_ord[1] = 4'h2;
    exp_ord[2] = 4'h8;
    exp_ord[3] = 4'h1;

    reset      = 1'b0;
    sel        = 4'd2;
    sel_valid  = 1'b1;
    modo_auto  = 1'b0;
    canal_mask = 4'h0;
    done       = 4'h0;

    // T1: request held during reset is not acted on
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_en", 32'(enable_cont), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    chk("rst_ch", 32'(ch_activo), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    chk("rst_inv", 32'(sel_invalido), 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_en_now", 32'(enable_cont), 32'h0);
    @(negedge clk);
    chk("rel_en_next", 32'(enable_cont), 32'h4);
    sel_valid = 1'b0;
    done = 4'h4;
    step();
    done = 4'h0;
    step();
    step();
    chk("rel_idle", 32'(busy), 32'h0);

    // T2/T3: table-driven single-request flow
    for (int i = 0; i < 14; i++) begin
      sel       = tbl[i].sel;
      sel_valid = tbl[i].sv;
      done      = tbl[i].dn;
      step();
      chk($sformatf("v%0d_en", i), 32'(enable_cont), 32'(tbl[i].en));
      chk($sformatf("v%0d_ch", i), 32'(ch_activo), 32'(tbl[i].ch));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_inv", i), 32'(sel_invalido), 32'(tbl[i].inv));
    end
    sel_valid = 1'b0;
    done      = 4'h0;

    // T4: round-robin over 1011
    reset_dut();
    canal_mask = 4'b1011;
    modo_auto  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_en(12, ok);
      chk($sformatf("rr%0d_found", k), 32'(ok), 32'h1);
      chk($sformatf("rr%0d_en", k), 32'(enable_cont), 32'(exp_ord[k]));
      step();
      step();
      done = enable_cont;
      step();
      done = 4'h0;
      if (k == 3) modo_auto = 1'b0;
      chk($sformatf("rr%0d_off", k), 32'(enable_cont), 32'h0);
    end
    step();
    step();
    step();
    chk("rr_end_busy", 32'(busy), 32'h0);
    chk("rr_end_en", 32'(enable_cont), 32'h0);

    // T5: timeout after exactly 8 enabled cycles, then auto moves to ch2
    reset_dut();
    canal_mask = 4'h0;
    sel        = 4'd1;
    sel_valid  = 1'b1;
    step();
    sel_valid = 1'b0;
    chk("to_en", 32'(enable_cont), 32'h2);
    ne = 1;
    nt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      ne += int'(enable_cont[1]);
      nt += int'(timeout_err);
    end
    chk("to_cycles", 32'(ne), 32'd8);
    chk("to_pulses", 32'(nt), 32'd1);
    canal_mask = 4'hF;
    modo_auto  = 1'b1;
    wait_en(6, ok);
    chk("to_next_found", 32'(ok), 32'h1);
    chk("to_next_en", 32'(enable_cont), 32'h4);
    done = 4'h4;
    step();
    done      = 4'h0;
    modo_auto = 1'b0;
    step();
    step();
    step();
    chk("to_next_idle", 32'(busy), 32'h0);

    // T6a: asynchronous reset mid-ACTIVO
    sel       = 4'd0;
    sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    step();
    chk("ar_pre", 32'(enable_cont), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_en", 32'(enable_cont), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // T6b: done on the timeout cycle wins, no timeout_err
    sel       = 4'd3;
    sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    repeat (7) step();
    chk("dt_en", 32'(enable_cont), 32'h8);
    done = 4'h8;
    step();
    done = 4'h0;
    chk("dt_off", 32'(enable_cont), 32'h0);
    chk("dt_tmo0", 32'(timeout_err), 32'h0);
    step();
    chk("dt_tmo1", 32'(timeout_err), 32'h0);
    step();
    chk("dt_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
